// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered unsigned adder among NUM_REQ requesters.
// The operands are captured at the grant, added in the next cycle, and the sum is held until the consumer accepts it.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [WIDTH:0]             res_sum_o,
  output logic [$clog2(NUM_REQ)-1:0] res_id_o,
  output logic                       busy_o
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_a, win_b;

  // Two passes give the wrap: first indices above last, then from 0 up to last.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && req_i[i] && (i > 32'(last_q))) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
        win_a     = op_a_i[i*WIDTH +: WIDTH];
        win_b     = op_b_i[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && req_i[i] && (i <= 32'(last_q))) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
        win_a     = op_a_i[i*WIDTH +: WIDTH];
        win_b     = op_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    res_id_d = res_id_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_id;
          last_d  = win_id;
          state_d = StCalc;
        end
      end
      StCalc: begin
        sum_d    = {1'b0, a_q} + {1'b0, b_q};
        res_id_d = id_q;
        state_d  = StHold;
      end
      StHold: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      last_q   <= IDW'(NUM_REQ - 1);
      id_q     <= '0;
      res_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      res_id_q <= res_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  // Grant is masked while reset is held so no operand capture is advertised.
  always_comb begin
    gnt_o = '0;
    if (!rst_i && (state_q == StIdle) && win_valid) gnt_o[win_id] = 1'b1;
  end

  assign res_valid_o = (state_q == StHold);
  assign res_sum_o   = sum_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NUM_REQ=4, WIDTH=7).
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        res_valid, res_ready;
  logic [7:0]  res_sum;
  logic [1:0]  res_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(4), .WIDTH(7)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .gnt_o       (gnt),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_id_o    (res_id),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_op(input int i, input logic [6:0] a, input logic [6:0] b);
    op_a[i*7 +: 7] = a;
    op_b[i*7 +: 7] = b;
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after the accept edge.
  task automatic run_op(input logic [3:0] rq, input logic [3:0] eg, input logic [7:0] es,
                        input logic [1:0] ei, input bit keep, input string tag);
    req = rq;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    @(negedge clk);
    if (!keep) req = '0;
    #1;
    check({tag, ".calc_gnt"}, 32'(gnt), 0);
    check({tag, ".calc_valid"}, 32'(res_valid), 0);
    check({tag, ".calc_busy"}, 32'(busy), 1);
    @(negedge clk);
    #1;
    check({tag, ".valid"}, 32'(res_valid), 1);
    check({tag, ".sum"}, 32'(res_sum), 32'(es));
    check({tag, ".id"}, 32'(res_id), 32'(ei));
    check({tag, ".hold_gnt"}, 32'(gnt), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b1111; res_ready = 1'b1; op_a = '0; op_b = '0;
    set_op(0, 7'd5, 7'd3);

    // T1 reset
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t1.gnt", 32'(gnt), 0);
    check("t1.valid", 32'(res_valid), 0);
    check("t1.busy", 32'(busy), 0);
    rst = 1'b0;
    run_op(4'b1111, 4'b0001, 8'd8, 2'd0, 1'b0, "t1");

    // T2 single op
    set_op(2, 7'd100, 7'd27);
    run_op(4'b0100, 4'b0100, 8'd127, 2'd2, 1'b0, "t2");

    // T3 carry into the top bit
    set_op(3, 7'h7F, 7'h7F);
    run_op(4'b1000, 4'b1000, 8'hFE, 2'd3, 1'b0, "t3");

    // T4 round-robin from last=3, one grant every 3 cycles
    set_op(0, 7'd1, 7'd2);
    set_op(1, 7'd10, 7'd20);
    set_op(3, 7'd127, 7'd1);
    run_op(4'b1111, 4'b0001, 8'd3, 2'd0, 1'b1, "t4a");
    run_op(4'b1111, 4'b0010, 8'd30, 2'd1, 1'b1, "t4b");
    run_op(4'b1111, 4'b0100, 8'd127, 2'd2, 1'b1, "t4c");
    run_op(4'b1111, 4'b1000, 8'd128, 2'd3, 1'b1, "t4d");
    run_op(4'b1111, 4'b0001, 8'd3, 2'd0, 1'b0, "t4e");

    // T5 backpressure in HOLD with a persistent requester
    set_op(0, 7'd64, 7'd63);
    res_ready = 1'b0;
    req = 4'b0001;
    #1;
    check("t5.gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5.valid", 32'(res_valid), 1);
      check("t5.sum", 32'(res_sum), 32'd127);
      check("t5.id", 32'(res_id), 0);
      check("t5.gnt0", 32'(gnt), 0);
      check("t5.busy", 32'(busy), 1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t5.idle_valid", 32'(res_valid), 0);
    check("t5.regrant", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5.second_sum", 32'(res_sum), 32'd127);
    @(negedge clk);

    // T6 reset during CALC
    req = 4'b0001;
    #1;
    check("t6.gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6.valid", 32'(res_valid), 0);
    check("t6.busy", 32'(busy), 0);
    rst = 1'b0;
    set_op(0, 7'd9, 7'd9);
    run_op(4'b1001, 4'b0001, 8'd18, 2'd0, 1'b0, "t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
